data_mem: RTL

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem.sv
// Byte-addressable data memory: B/H/W loads and stores, one request per cycle, response one cycle later.
// Define DATA_MEM_MISALIGN_EN to split misaligned H/W accesses over two cycles; otherwise they fault.
module data_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int INIT_ZERO  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_access,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

`ifdef DATA_MEM_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    localparam int          WORD_AW   = ADDR_WIDTH - 2;
    localparam int          WORDS     = 1 << WORD_AW;
    localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem [WORDS] = '{default: INIT_WORD};

    // Sign/zero extension of the byte-aligned raw load data.
    function automatic logic [31:0] load_extend(input logic [2:0] access, input logic [31:0] raw);
        logic signed [7:0]  raw_b;
        logic signed [15:0] raw_h;
        logic signed [31:0] ext;
        raw_b = raw[7:0];
        raw_h = raw[15:0];
        case (access)
            3'b000:  ext = 32'(raw_b);
            3'b001:  ext = 32'(raw_h);
            3'b100:  ext = {24'h0, raw[7:0]};
            3'b101:  ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

    // ---- stage p0: request decode ----
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [WORD_AW-1:0]    widx_p0;
    logic [1:0]            off_p0;
    logic                  vld_p0;
    logic                  illegal_p0;
    logic                  misalign_p0;
    logic                  fault_p0;
    logic                  split_start_p0;
    logic [3:0]            size_mask_p0;
    logic [7:0]            lane_p0;
    logic [63:0]           wdata_p0;
    logic                  addr_unused;

    assign addr_p0     = req_addr[ADDR_WIDTH-1:0];
    assign addr_unused = ^req_addr[31:ADDR_WIDTH];
    assign widx_p0     = addr_p0[ADDR_WIDTH-1:2];
    assign off_p0      = addr_p0[1:0];
    assign vld_p0      = req_valid && (state_q == IDLE);

    always_comb begin
        illegal_p0 = (req_access == 3'b011) || (req_access[2:1] == 2'b11) ||
                     (req_store && req_access[2]);
        case (req_access[1:0])
            2'b00:   size_mask_p0 = 4'b0001;
            2'b01:   size_mask_p0 = 4'b0011;
            default: size_mask_p0 = 4'b1111;
        endcase
        misalign_p0    = ((req_access[1:0] == 2'b01) && off_p0[0]) ||
                         ((req_access[1:0] == 2'b10) && (off_p0 != 2'b00));
        fault_p0       = illegal_p0 || (misalign_p0 && !MISALIGN_EN);
        split_start_p0 = MISALIGN_EN && vld_p0 && !illegal_p0 && misalign_p0;
        lane_p0        = {4'b0000, size_mask_p0} << off_p0;
        wdata_p0       = {32'h0, req_wdata} << {off_p0, 3'b000};
    end

    // ---- stage p1: second-word context of a split access ----
    logic [WORD_AW-1:0] split_idx_p1;
    logic [1:0]         split_off_p1;
    logic [2:0]         split_access_p1;
    logic               split_store_p1;
    logic [3:0]         split_be_p1;
    logic [31:0]        split_wdata_p1;
    logic [31:0]        split_lo_p1;

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (split_start_p0) state_d = SPLIT;
            end
            SPLIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Single array port: the request's word in IDLE, the following word in SPLIT.
    logic [WORD_AW-1:0] wr_idx;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic [31:0]        rd_word;

    always_comb begin
        wr_idx  = widx_p0;
        wr_data = wdata_p0[31:0];
        wr_be   = 4'b0000;
        if (state_q == SPLIT) begin
            wr_idx  = split_idx_p1;
            wr_data = split_wdata_p1;
            if (split_store_p1) wr_be = split_be_p1;
        end else if (vld_p0 && req_store && !fault_p0) begin
            wr_be = lane_p0[3:0];
        end
        if (rst) wr_be = 4'b0000;
    end

    assign rd_word = mem[wr_idx];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (split_start_p0) begin
            split_idx_p1    <= widx_p0 + WORD_AW'(1);
            split_off_p1    <= off_p0;
            split_access_p1 <= req_access;
            split_store_p1  <= req_store;
            split_be_p1     <= lane_p0[7:4];
            split_wdata_p1  <= wdata_p0[63:32];
            split_lo_p1     <= rd_word;
        end
    end

    // ---- stage p1: response ----
    logic [31:0] raw_al_p0;
    logic [63:0] split_cat_p1;
    logic [31:0] raw_sp_p1;

    assign raw_al_p0    = rd_word >> {off_p0, 3'b000};
    assign split_cat_p1 = {rd_word, split_lo_p1} >> {split_off_p1, 3'b000};
    assign raw_sp_p1    = split_cat_p1[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            if (state_q == SPLIT) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= split_store_p1 ? 32'h0 : load_extend(split_access_p1, raw_sp_p1);
            end else if (vld_p0 && !split_start_p0) begin
                rsp_valid <= 1'b1;
                rsp_fault <= fault_p0;
                rsp_rdata <= (req_store || fault_p0) ? 32'h0 : load_extend(req_access, raw_al_p0);
            end
        end
    end

endmodule
